instr_mem_loadable: RTL

Parametrised, clocked instruction memory for the nRisc core, replacing the fixed-content, combinational program store.
- Programs are loaded at run time through a byte/word-serial load port; a small controller tracks the load pointer and program length.
- Fetches are registered, take one cycle, and carry a valid flag.
- Fetches beyond the loaded program return a NOP and raise a fault flag.
- Sits between the boot/debug loader and the fetch stage (PC register).

---
 rtl/instr_mem_loadable_if.sv | 35 +++
 rtl/instr_mem_loadable.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/instr_mem_loadable_if.sv
// Load/fetch bus between the boot loader, the fetch stage and the instruction memory.
// Latency: none; wires only.
// Backpressure: load words are accepted only while load_ready is high; fetches are never stalled.
interface instr_mem_loadable_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    // Loader side
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic              reload;
    logic              loaded;
    logic [ADDR_W:0]   prog_len;

    // Fetch side
    logic              fetch_en;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instruction;
    logic              instr_valid;
    logic              pc_fault;

    // Loader + fetch stage drive requests and observe status/results
    modport master (
        output load_valid, load_data, load_last, reload, fetch_en, pc,
        input  load_ready, loaded, prog_len, instruction, instr_valid, pc_fault
    );

    // Memory consumes requests and produces status/results
    modport slave (
        input  load_valid, load_data, load_last, reload, fetch_en, pc,
        output load_ready, loaded, prog_len, instruction, instr_valid, pc_fault
    );
endinterface

// File: rtl/instr_mem_loadable.sv
// Run-time loadable instruction memory: serial program load, then registered fetch with range check.
// Latency: fetch -> instruction/instr_valid 1 cycle; loaded words visible once RUN is entered.
// Backpressure: load_ready high only in LOAD; fetches ignored in LOAD, one result per cycle in RUN.
module instr_mem_loadable #(
    parameter int                 DATA_W    = 8,
    parameter int                 ADDR_W    = 8,
    parameter logic [DATA_W-1:0]  NOP_INSTR = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    instr_mem_loadable_if.slave   bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Control state
    state_t             state_q,       state_d;
    logic [ADDR_W-1:0]  ptr_q,         ptr_d;
    logic [ADDR_W:0]    prog_len_q,    prog_len_d;
    logic               load_ready_q,  load_ready_d;
    logic               loaded_q,      loaded_d;
    logic [DATA_W-1:0]  instruction_q, instruction_d;
    logic               instr_valid_q, instr_valid_d;
    logic               pc_fault_q,    pc_fault_d;

    // Program storage; deliberately has no reset so a reset does not wipe it
    logic [DATA_W-1:0]  mem [DEPTH];

    logic               mem_we;
    logic [ADDR_W-1:0]  mem_waddr;
    logic [DATA_W-1:0]  mem_wdata;

    logic               load_fire;
    logic               fetch_fire;
    logic               ptr_at_end;
    logic               pc_in_range;

    // Qualified events; reload takes priority over any same-cycle load or fetch
    always_comb begin
        load_fire   = (state_q == ST_LOAD) && bus.load_valid && !bus.reload;
        fetch_fire  = (state_q == ST_RUN)  && bus.fetch_en   && !bus.reload;
        ptr_at_end  = (ptr_q == ADDR_W'(DEPTH - 1));
        pc_in_range = ({1'b0, bus.pc} < prog_len_q);
    end

    // Next-state, load pointer, program length and fetch result computation
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        prog_len_d    = prog_len_q;
        instruction_d = instruction_q;
        instr_valid_d = 1'b0;
        pc_fault_d    = 1'b0;
        mem_we        = 1'b0;
        mem_waddr     = ptr_q;
        mem_wdata     = bus.load_data;

        if (bus.reload) begin
            state_d    = ST_LOAD;
            ptr_d      = '0;
            prog_len_d = '0;
        end else begin
            unique case (state_q)
                ST_LOAD: begin
                    if (load_fire) begin
                        mem_we     = 1'b1;
                        prog_len_d = {1'b0, ptr_q} + (ADDR_W+1)'(1);
                        // The last address closes the program: the pointer parks
                        // there instead of wrapping onto word 0.
                        ptr_d      = ptr_at_end ? ptr_q : ptr_q + ADDR_W'(1);
                        if (bus.load_last || ptr_at_end) begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (fetch_fire) begin
                        instr_valid_d = 1'b1;
                        if (pc_in_range) begin
                            instruction_d = mem[bus.pc];
                        end else begin
                            instruction_d = NOP_INSTR;
                            pc_fault_d    = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_LOAD;
                end
            endcase
        end

        // Status outputs are registered from the next state so they switch
        // together with the state itself.
        load_ready_d = (state_d == ST_LOAD);
        loaded_d     = (state_d == ST_RUN);
    end

    // Control and output registers; async active-low reset returns to an empty LOAD
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_LOAD;
            ptr_q         <= '0;
            prog_len_q    <= '0;
            load_ready_q  <= 1'b1;
            loaded_q      <= 1'b0;
            instruction_q <= NOP_INSTR;
            instr_valid_q <= 1'b0;
            pc_fault_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            prog_len_q    <= prog_len_d;
            load_ready_q  <= load_ready_d;
            loaded_q      <= loaded_d;
            instruction_q <= instruction_d;
            instr_valid_q <= instr_valid_d;
            pc_fault_q    <= pc_fault_d;
        end
    end

    // Program array write port; writes are suppressed while reset is held
    always_ff @(posedge clock) begin
        if (mem_we && reset) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.load_ready  = load_ready_q;
    assign bus.loaded      = loaded_q;
    assign bus.prog_len    = prog_len_q;
    assign bus.instruction = instruction_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.pc_fault    = pc_fault_q;

    // The program can never be longer than the array
    a_len_bound: assert property (@(posedge clock) disable iff (!reset)
        prog_len_q <= (ADDR_W+1)'(DEPTH));

    // Exactly one of LOAD / RUN is advertised at any time
    a_status_onehot: assert property (@(posedge clock) disable iff (!reset)
        load_ready_q != loaded_q);

    // A fault is only ever reported alongside a valid result
    a_fault_qualified: assert property (@(posedge clock) disable iff (!reset)
        pc_fault_q |-> instr_valid_q);

endmodule
